// File: rtl/inst_mem_loader.sv
// Debug-write side of the instruction memory: packs a big-endian byte stream into words and
// strobes them into ascending word addresses. Define INST_LOADER_CHECKSUM_EN for the XOR trailer.
module inst_mem_loader #(
    parameter int unsigned          NBITS     = 8,
    parameter int unsigned          INST_BITS = 32,
    parameter int unsigned          CELLS     = 256,
    parameter logic [INST_BITS-1:0] HALT_INST = 32'hFFFFFFFF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [NBITS-1:0]     i_rx_data,
    input  logic                 i_rx_valid,
    output logic                 o_rx_ready,
    output logic [INST_BITS-1:0] o_dbg_addr,
    output logic [INST_BITS-1:0] o_dbg_inst,
    output logic                 o_dbg_wr_en,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_overflow,
    output logic [INST_BITS-1:0] o_inst_count,
    output logic                 o_chk_err
);

    localparam int unsigned          BYTES      = INST_BITS / NBITS;
    localparam int unsigned          IDX_W      = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(BYTES - 1);
    localparam logic [IDX_W-1:0]     IDX_STEP   = IDX_W'(1);
    localparam logic [INST_BITS-1:0] LAST_ADDR  = INST_BITS'(CELLS - 4);
    localparam logic [INST_BITS-1:0] ADDR_STEP  = INST_BITS'(4);
    localparam logic [INST_BITS-1:0] COUNT_STEP = INST_BITS'(1);

    typedef enum logic [2:0] {StIdle, StRecv, StLatch, StStrobe, StCheck, StDone} state_t;

    state_t                     state;
    logic [IDX_W-1:0]           idx;
    logic [INST_BITS-NBITS-1:0] shift;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [NBITS-1:0]           csum;
    logic                       chk_err;
    assign o_chk_err = chk_err;
`else
    assign o_chk_err = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= StIdle;
            idx          <= '0;
            shift        <= '0;
            o_rx_ready   <= 1'b0;
            o_dbg_addr   <= '0;
            o_dbg_inst   <= '0;
            o_dbg_wr_en  <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_overflow   <= 1'b0;
            o_inst_count <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
            csum         <= '0;
            chk_err      <= 1'b0;
`endif
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (i_start) begin
                        state        <= StRecv;
                        idx          <= '0;
                        o_rx_ready   <= 1'b1;
                        o_busy       <= 1'b1;
                        o_done       <= 1'b0;
                        o_overflow   <= 1'b0;
                        o_dbg_addr   <= '0;
                        o_inst_count <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
                        csum         <= '0;
                        chk_err      <= 1'b0;
`endif
                    end
                end
                StRecv: begin
                    if (i_rx_valid && o_rx_ready) begin
`ifdef INST_LOADER_CHECKSUM_EN
                        csum <= csum ^ i_rx_data;
`endif
                        if (idx == LAST_IDX) begin
                            o_dbg_inst <= {shift, i_rx_data};
                            o_rx_ready <= 1'b0;
                            idx        <= '0;
                            state      <= StLatch;
                        end else begin
                            shift <= {shift[INST_BITS-2*NBITS-1:0], i_rx_data};
                            idx   <= idx + IDX_STEP;
                        end
                    end
                end
                StLatch: state <= StStrobe;
                // Two cycles here: first raises wr_en, second drops it and decides what follows.
                StStrobe: begin
                    if (!o_dbg_wr_en) begin
                        o_dbg_wr_en <= 1'b1;
                    end else begin
                        o_dbg_wr_en  <= 1'b0;
                        o_inst_count <= o_inst_count + COUNT_STEP;
                        if (o_dbg_inst == HALT_INST) begin
`ifdef INST_LOADER_CHECKSUM_EN
                            state      <= StCheck;
                            o_rx_ready <= 1'b1;
`else
                            state      <= StDone;
                            o_busy     <= 1'b0;
                            o_done     <= 1'b1;
`endif
                        end else if (o_dbg_addr >= LAST_ADDR) begin
                            state      <= StDone;
                            o_busy     <= 1'b0;
                            o_done     <= 1'b1;
                            o_overflow <= 1'b1;
                        end else begin
                            o_dbg_addr <= o_dbg_addr + ADDR_STEP;
                            o_rx_ready <= 1'b1;
                            state      <= StRecv;
                        end
                    end
                end
`ifdef INST_LOADER_CHECKSUM_EN
                StCheck: begin
                    if (i_rx_valid && o_rx_ready) begin
                        chk_err    <= (i_rx_data != csum);
                        o_rx_ready <= 1'b0;
                        o_busy     <= 1'b0;
                        o_done     <= 1'b1;
                        state      <= StDone;
                    end
                end
`endif
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: a full-size instance plus a 16-cell instance for overflow.
`timescale 1ns/1ps
module tb_inst_mem_loader;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, start_s, rx_valid;
    logic [7:0]  rx_data;
    logic        rdy, wr, busy, done, ovf, cerr;
    logic [31:0] addr, inst, cnt;
    logic        rdy_s, wr_s, busy_s, done_s, ovf_s, cerr_s;
    logic [31:0] addr_s, inst_s, cnt_s;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_accept = 0;
    int rise_cyc = 0;
    logic [7:0] xor_acc = 8'h00;
    logic wr_prev = 1'b0;
    logic wr_prev_s = 1'b0;
    wr_t exp_q[$];
    wr_t exp_qs[$];

    inst_mem_loader dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_rx_ready(rdy), .o_dbg_addr(addr), .o_dbg_inst(inst), .o_dbg_wr_en(wr),
        .o_busy(busy), .o_done(done), .o_overflow(ovf), .o_inst_count(cnt), .o_chk_err(cerr)
    );

    inst_mem_loader #(.CELLS(16)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_start(start_s), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_rx_ready(rdy_s), .o_dbg_addr(addr_s), .o_dbg_inst(inst_s), .o_dbg_wr_en(wr_s),
        .o_busy(busy_s), .o_done(done_s), .o_overflow(ovf_s), .o_inst_count(cnt_s),
        .o_chk_err(cerr_s)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: pop one expected write per wr_en rising edge.
    always @(negedge clk) begin
        wr_t e;
        if (wr && !wr_prev) begin
            rise_cyc = cyc;
            if (exp_q.size() == 0) check("unexpected_write", addr, 32'hxxxx_xxxx);
            else begin
                e = exp_q.pop_front();
                check("wr_addr", addr, e.addr);
                check("wr_inst", inst, e.inst);
            end
        end
        if (wr && wr_prev) check("wr_en_double", 32'(wr), 32'd0);
        wr_prev <= wr;
    end

    always @(negedge clk) begin
        wr_t e;
        if (wr_s && !wr_prev_s) begin
            if (exp_qs.size() == 0) check("unexpected_write_s", addr_s, 32'hxxxx_xxxx);
            else begin
                e = exp_qs.pop_front();
                check("wr_addr_s", addr_s, e.addr);
                check("wr_inst_s", inst_s, e.inst);
            end
        end
        if (wr_s && wr_prev_s) check("wr_en_double_s", 32'(wr_s), 32'd0);
        wr_prev_s <= wr_s;
    end

    task automatic pulse_start(input bit sm);
        @(negedge clk);
        if (sm) start_s = 1'b1; else start = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        start   = 1'b0;
        if (!sm) xor_acc = 8'h00;
    endtask

    // Called just after a negedge; returns at the negedge following the accepting posedge.
    task automatic send(input bit sm, input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!(sm ? rdy_s : rdy) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check("send_timeout", 32'(n), 32'd0);
            rx_valid = 1'b0;
        end else begin
            last_accept = cyc + 1;
            if (!sm) xor_acc = xor_acc ^ b;
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic send_word(input bit sm, input logic [31:0] a, input logic [31:0] w,
                             input int gap);
        logic [31:0] v;
        if (sm) exp_qs.push_back('{addr: a, inst: w});
        else    exp_q.push_back('{addr: a, inst: w});
        v = w;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) repeat (gap) @(negedge clk);
            send(sm, v[31:24]);
            v = v << 8;
        end
    endtask

    task automatic wait_done(input bit sm);
        int n = 0;
        while (!(sm ? done_s : done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(sm ? "done_s" : "done", 32'(sm ? done_s : done), 32'd1);
    endtask

    task automatic finish_big();
`ifdef INST_LOADER_CHECKSUM_EN
        send(1'b0, xor_acc);
`endif
        wait_done(1'b0);
        check("chk_err", 32'(cerr), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_s = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 32'(rdy), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", addr, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_count", cnt, 32'd0);

        // 1: basic two-word program
        pulse_start(1'b0);
        check("start_busy", 32'(busy), 32'd1);
        send_word(1'b0, 32'd0, 32'h20080005, 0);
        send_word(1'b0, 32'd4, 32'hFFFFFFFF, 0);
        finish_big();
        check("t1_count", cnt, 32'd2);
        check("t1_ovf", 32'(ovf), 32'd0);
        check("t1_addr_held", addr, 32'd4);

        // 2: throttled source, strobe timing
        pulse_start(1'b0);
        send_word(1'b0, 32'd0, 32'h8C010004, 2);
        check("t2_latch_ready", 32'(rdy), 32'd0);
        check("t2_latch_inst", inst, 32'h8C010004);
        @(negedge clk);
        check("t2_strobe_ready", 32'(rdy), 32'd0);
        check("t2_pre_wr", 32'(wr), 32'd0);
        @(negedge clk);
        check("t2_wr_high", 32'(wr), 32'd1);
        check("t2_wr_ready", 32'(rdy), 32'd0);
        @(negedge clk);
        check("t2_wr_low", 32'(wr), 32'd0);
        check("t2_rise_lat", 32'(rise_cyc - last_accept), 32'd2);
        check("t2_ready_back", 32'(rdy), 32'd1);
        send_word(1'b0, 32'd4, 32'hFFFFFFFF, 2);
        finish_big();
        check("t2_count", cnt, 32'd2);

        // 3: 16-cell overflow
        pulse_start(1'b1);
        send_word(1'b1, 32'd0,  32'h11223344, 0);
        send_word(1'b1, 32'd4,  32'h55667788, 0);
        send_word(1'b1, 32'd8,  32'h99AABBCC, 0);
        send_word(1'b1, 32'd12, 32'h01020304, 0);
        wait_done(1'b1);
        check("t3_ovf", 32'(ovf_s), 32'd1);
        check("t3_ready", 32'(rdy_s), 32'd0);
        check("t3_count", cnt_s, 32'd4);
        check("t3_chk_err", 32'(cerr_s), 32'd0);
        rx_data = 8'hAA;
        rx_valid = 1'b1;
        repeat (5) @(negedge clk);
        rx_valid = 1'b0;
        check("t3_count_after", cnt_s, 32'd4);
        check("t3_addr_after", addr_s, 32'd12);

        // 4: reset mid-word discards partial bytes
        pulse_start(1'b0);
        send(1'b0, 8'hDE);
        send(1'b0, 8'hAD);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4_rst_busy", 32'(busy), 32'd0);
        check("t4_rst_done", 32'(done), 32'd0);
        check("t4_rst_inst", inst, 32'd0);
        check("t4_rst_ovf_s", 32'(ovf_s), 32'd0);
        pulse_start(1'b0);
        send_word(1'b0, 32'd0, 32'h00000001, 0);
        send_word(1'b0, 32'd4, 32'hFFFFFFFF, 0);
        finish_big();
        check("t4_count", cnt, 32'd2);

        // 5: restart from DONE; start mid-RECV ignored
        pulse_start(1'b0);
        check("t5_done_cleared", 32'(done), 32'd0);
        exp_q.push_back('{addr: 32'd0, inst: 32'hFFFFFFFF});
        send(1'b0, 8'hFF);
        pulse_start(1'b0);
        xor_acc = 8'hFF;
        for (int i = 0; i < 3; i++) send(1'b0, 8'hFF);
        finish_big();
        check("t5_count", cnt, 32'd1);
        check("t5_addr", addr, 32'd0);
        check("t5_ovf", 32'(ovf), 32'd0);

`ifdef INST_LOADER_CHECKSUM_EN
        // 6: checksum trailer good then bad
        pulse_start(1'b0);
        send_word(1'b0, 32'd0, 32'h01020304, 0);
        send_word(1'b0, 32'd4, 32'hFFFFFFFF, 0);
        send(1'b0, 8'h04);
        wait_done(1'b0);
        check("t6_good", 32'(cerr), 32'd0);
        pulse_start(1'b0);
        send_word(1'b0, 32'd0, 32'h01020304, 0);
        send_word(1'b0, 32'd4, 32'hFFFFFFFF, 0);
        send(1'b0, 8'h05);
        wait_done(1'b0);
        check("t6_bad", 32'(cerr), 32'd1);
`endif

        repeat (3) @(negedge clk);
        check("q_empty", 32'(exp_q.size()), 32'd0);
        check("qs_empty", 32'(exp_qs.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
